aes_round_sequencer: RTL
========================

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, meaning: number of cipher rounds after the initial key addition (legal range 1..14).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  upstream packet present.
REQ-005 in_header  input  4  packet header of the offered 132-bit packet; 0 denotes an empty packet.
REQ-006 in_ready  output  1  sequencer can accept a packet this cycle.
REQ-007 key_req  output  1  request to the key store for the round key at round_idx.
REQ-008 key_valid  input  1  key store asserts that key_in for round_idx is stable this cycle.
REQ-009 round_idx  output  4  current round number, 0..NUM_ROUNDS.
REQ-010 sub_en, shift_en, mix_en, ark_en  output  1 each  one-cycle stage enables for SubBytes, ShiftRows, MixColumns and AddRoundKeys.
REQ-011 out_valid  output  1  encrypted packet complete.
REQ-012 out_header  output  4  header of the completed packet.
REQ-013 out_ready  input  1  downstream accepts the completed packet.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL be a FSM with states IDLE, FETCH, EXEC and DONE, plus a 4-bit round counter and a 4-bit header register.
REQ-016 IDLE: in_ready=1; on in_valid with in_header!=0, latch in_header, clear round counter, go to FETCH.
REQ-017 IDLE: in_valid with in_header==0 SHALL be consumed (handshake completes) and dropped; state stays IDLE and no enables fire.
REQ-018 in_ready SHALL be 0 in FETCH, EXEC and DONE.
REQ-019 FETCH: key_req=1 and round_idx=counter; stay in FETCH while key_valid=0; on key_valid=1 go to EXEC next cycle.
REQ-020 EXEC lasts exactly one cycle; ark_en=1 in every EXEC cycle.
REQ-021 EXEC with round 0: sub_en=shift_en=mix_en=0 (initial key addition only).
REQ-022 EXEC with 1 <= round <= NUM_ROUNDS-1: sub_en=shift_en=mix_en=1.
REQ-023 EXEC with round == NUM_ROUNDS: sub_en=shift_en=1, mix_en=0.
REQ-024 Leaving EXEC: if round < NUM_ROUNDS, increment counter and go to FETCH; otherwise go to DONE.
REQ-025 Stage enables and key_req SHALL be 0 outside EXEC and FETCH respectively.
REQ-026 DONE: out_valid=1 and out_header=latched header, held stable until out_ready=1; on out_valid and out_ready, go to IDLE next cycle.
REQ-027 out_header SHALL hold its last value outside DONE; out_valid SHALL be 0 outside DONE.
REQ-028 With key_valid held at 1, out_valid SHALL rise exactly 2*NUM_ROUNDS+2 rising edges after the accepting edge (22 for the default).
REQ-029 The round counter SHALL never exceed NUM_ROUNDS and SHALL never wrap.
REQ-030 key_valid while not in FETCH SHALL be ignored.
REQ-031 A new packet SHALL NOT be accepted in the DONE-to-IDLE transition cycle; in_ready returns only in IDLE.

Reset
REQ-032 While rst=1: state=IDLE, round counter=0, header register=0, and all outputs 0 except in_ready=1.
REQ-033 rst asserted mid-packet, in any state, SHALL abandon the packet immediately with no further enables or out_valid pulse.
REQ-034 After rst deasserts, the first rising edge SHALL accept a packet if in_valid=1 and in_header!=0.

Verification
REQ-035 key_valid=1, out_ready=1, in_header=4'hA for one cycle -> ark_en pulses 11 times; mix_en is high only for rounds 1..9; out_valid rises 22 edges after accept with out_header=4'hA.
REQ-036 key_valid is held 0 for 3 cycles in round 5 FETCH -> key_req and round_idx=5 are stable for 4 cycles, no enables fire, and total latency is 25.
REQ-037 in_header=0 with in_valid=1 -> in_ready=1, busy stays 0, no enables, no out_valid.
REQ-038 out_ready is held 0 for 5 cycles in DONE -> out_valid and out_header are stable, in_ready=0, and a new in_valid is not accepted until the cycle after the handshake.
REQ-039 rst pulsed during round 3 EXEC -> all outputs go to reset values asynchronously, and the next packet starts at round_idx=0.
REQ-040 Two back-to-back packets with headers 4'h1 and 4'h2 -> two out_valid handshakes carrying 1 then 2, with no overlap of their enables.

Source files
------------

// File: rtl/aes_round_sequencer_if.sv
// Handshake and control bundle between the AES round sequencer and its environment:
// the packet input, the key store, the datapath stage enables and the packet output.
interface aes_round_sequencer_if;
  logic       in_valid;
  logic [3:0] in_header;
  logic       in_ready;
  logic       key_req;
  logic       key_valid;
  logic [3:0] round_idx;
  logic       sub_en;
  logic       shift_en;
  logic       mix_en;
  logic       ark_en;
  logic       out_valid;
  logic [3:0] out_header;
  logic       out_ready;
  logic       busy;

  modport master (
    input  in_valid, in_header, key_valid, out_ready,
    output in_ready, key_req, round_idx, sub_en, shift_en, mix_en, ark_en,
           out_valid, out_header, busy
  );

  modport slave (
    output in_valid, in_header, key_valid, out_ready,
    input  in_ready, key_req, round_idx, sub_en, shift_en, mix_en, ark_en,
           out_valid, out_header, busy
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: walks one packet through the initial key addition and
// NUM_ROUNDS cipher rounds, fetching each round key before firing its stage enables.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_round_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] round_r;
  logic [3:0] round_next_s;
  logic [3:0] hdr_r;
  logic [3:0] hdr_next_s;

  logic       in_ready_r,   in_ready_s;
  logic       key_req_r,    key_req_s;
  logic [3:0] round_idx_r,  round_idx_s;
  logic       sub_en_r,     sub_en_s;
  logic       shift_en_r,   shift_en_s;
  logic       mix_en_r,     mix_en_s;
  logic       ark_en_r,     ark_en_s;
  logic       out_valid_r,  out_valid_s;
  logic [3:0] out_header_r, out_header_s;
  logic       busy_r,       busy_s;

  // State, round counter and header registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      round_r <= 4'd0;
      hdr_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      round_r <= round_next_s;
      hdr_r   <= hdr_next_s;
    end
  end

  // Next-state logic; empty packets are handshaken in IDLE but never leave it
  always_comb begin
    state_next_s = state_r;
    round_next_s = round_r;
    hdr_next_s   = hdr_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && (bus.in_header != 4'd0)) begin
          state_next_s = FETCH;
          round_next_s = 4'd0;
          hdr_next_s   = bus.in_header;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        if (bus.key_valid) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = FETCH;
        end
      end
      EXEC: begin
        if (round_r < LAST_ROUND) begin
          state_next_s = FETCH;
          round_next_s = round_r + 4'd1;
        end else begin
          state_next_s = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
        round_next_s = 4'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    in_ready_s   = 1'b0;
    key_req_s    = 1'b0;
    round_idx_s  = round_next_s;
    sub_en_s     = 1'b0;
    shift_en_s   = 1'b0;
    mix_en_s     = 1'b0;
    ark_en_s     = 1'b0;
    out_valid_s  = 1'b0;
    out_header_s = out_header_r;
    busy_s       = 1'b1;
    case (state_next_s)
      IDLE: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
      end
      FETCH: begin
        key_req_s = 1'b1;
      end
      EXEC: begin
        ark_en_s = 1'b1;
        // Round 0 is key addition only; the final round skips MixColumns
        if (round_next_s != 4'd0) begin
          sub_en_s   = 1'b1;
          shift_en_s = 1'b1;
          if (round_next_s != LAST_ROUND) begin
            mix_en_s = 1'b1;
          end else begin
            mix_en_s = 1'b0;
          end
        end else begin
          sub_en_s   = 1'b0;
          shift_en_s = 1'b0;
          mix_en_s   = 1'b0;
        end
      end
      DONE: begin
        out_valid_s  = 1'b1;
        out_header_s = hdr_next_s;
      end
      default: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r   <= 1'b1;
      key_req_r    <= 1'b0;
      round_idx_r  <= 4'd0;
      sub_en_r     <= 1'b0;
      shift_en_r   <= 1'b0;
      mix_en_r     <= 1'b0;
      ark_en_r     <= 1'b0;
      out_valid_r  <= 1'b0;
      out_header_r <= 4'd0;
      busy_r       <= 1'b0;
    end else begin
      in_ready_r   <= in_ready_s;
      key_req_r    <= key_req_s;
      round_idx_r  <= round_idx_s;
      sub_en_r     <= sub_en_s;
      shift_en_r   <= shift_en_s;
      mix_en_r     <= mix_en_s;
      ark_en_r     <= ark_en_s;
      out_valid_r  <= out_valid_s;
      out_header_r <= out_header_s;
      busy_r       <= busy_s;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.key_req    = key_req_r;
  assign bus.round_idx  = round_idx_r;
  assign bus.sub_en     = sub_en_r;
  assign bus.shift_en   = shift_en_r;
  assign bus.mix_en     = mix_en_r;
  assign bus.ark_en     = ark_en_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_header = out_header_r;
  assign bus.busy       = busy_r;

endmodule
